// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Memory-stage data-memory access controller. Sits directly downstream of the
// byte-mask generator, issues load/store requests to the data cache, stalls
// the pipeline until the cache answers and presents extended load data for
// one cycle. Misaligned or unrecognised accesses are flagged, never issued.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_read/write    MEM-stage load / store (mutually exclusive)
//   alu_out           effective byte address
//   funct3            size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rs2_data          store source, unshifted
//   byte_mask         mask from the mask generator, 0 = misaligned
//   dmem_resp/rdata   cache completion strobe and read word
//   dmem_*            cache request interface (address, read, write, wdata, byte_enable)
//   mem_stall         freeze stages at and before MEM
//   load_data/valid   extended load result, valid for one cycle
//   misaligned        one-cycle misaligned-access flag
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_out,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2_data,
  input  logic [3:0]  byte_mask,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  be_r;
  logic [2:0]  funct3_r;
  logic [1:0]  offs_r;
  logic        is_load_r;
  logic        is_store_r;
  logic [31:0] load_data_r;

  logic        op_s;
  logic        bad_s;
  logic        issue_s;

  // Only the five defined access encodings are legal.
  function automatic logic funct3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
      default:                                funct3_ok = 1'b0;
    endcase
  endfunction

  // Pick the addressed byte/half/word out of the cache word and extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  extract_load = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extract_load = {24'd0, sh[7:0]};
      3'b001:  extract_load = {{16{sh[15]}}, sh[15:0]};
      3'b101:  extract_load = {16'd0, sh[15:0]};
      3'b010:  extract_load = sh;
      default: extract_load = 32'd0;
    endcase
  endfunction

  assign op_s  = mem_read | mem_write;
  assign bad_s = op_s & ((byte_mask == 4'b0000) | ~funct3_ok(funct3));
  // rst_n gates the combinational issue path so nothing leaks out during reset.
  assign issue_s = rst_n & (state_r == IDLE) & op_s & ~bad_s;

  // Request/stall outputs: live from the inputs in the issue cycle, from the
  // latched copy while waiting for the cache.
  always_comb begin
    dmem_address     = 32'd0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_wdata       = 32'd0;
    dmem_byte_enable = 4'b0000;
    mem_stall        = 1'b0;
    misaligned       = 1'b0;
    load_valid       = 1'b0;
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          dmem_address     = {alu_out[31:2], 2'b00};
          dmem_read        = mem_read;
          dmem_write       = mem_write;
          dmem_wdata       = rs2_data << {alu_out[1:0], 3'b000};
          dmem_byte_enable = mem_write ? byte_mask : 4'b1111;
          mem_stall        = 1'b1;
        end else begin
          misaligned = rst_n & bad_s;
        end
      end
      BUSY: begin
        dmem_address     = addr_r;
        dmem_read        = is_load_r;
        dmem_write       = is_store_r;
        dmem_wdata       = wdata_r;
        dmem_byte_enable = be_r;
        mem_stall        = 1'b1;
      end
      DONE: begin
        load_valid = is_load_r;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  assign load_data = load_data_r;

  // Access sequencing, request latching and load-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      be_r        <= 4'b0000;
      funct3_r    <= 3'b000;
      offs_r      <= 2'b00;
      is_load_r   <= 1'b0;
      is_store_r  <= 1'b0;
      load_data_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            addr_r     <= {alu_out[31:2], 2'b00};
            wdata_r    <= rs2_data << {alu_out[1:0], 3'b000};
            be_r       <= mem_write ? byte_mask : 4'b1111;
            funct3_r   <= funct3;
            offs_r     <= alu_out[1:0];
            is_load_r  <= mem_read;
            is_store_r <= mem_write;
            if (dmem_resp) begin
              state_r <= DONE;
              if (mem_read) begin
                load_data_r <= extract_load(dmem_rdata, funct3, alu_out[1:0]);
              end
            end else begin
              state_r <= BUSY;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            state_r <= DONE;
            if (is_load_r) begin
              load_data_r <= extract_load(dmem_rdata, funct3_r, offs_r);
            end
          end else begin
            state_r <= BUSY;
          end
        end
        // The instruction still on the inputs here was already issued.
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-memory access controller, directly downstream of the byte-mask generator. It takes the MEM-stage load/store request and the generated byte mask, drives the data-cache request interface, and holds the pipeline stalled until the cache responds. On completion it presents sign- or zero-extended load data for one cycle. Misaligned accesses are flagged and never issued.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  MEM-stage instruction is a load
- mem_write  in  1  MEM-stage instruction is a store; never high together with mem_read
- alu_out  in  32  effective byte address
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rs2_data  in  32  store source, unshifted
- byte_mask  in  4  mask from the mask generator; 4'b0000 means misaligned
- dmem_resp  in  1  cache completion strobe, one cycle
- dmem_rdata  in  32  cache read word, valid with dmem_resp
- dmem_address  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_wdata  out  32  rs2_data << (8*addr[1:0])
- dmem_byte_enable  out  4  byte enables
- mem_stall  out  1  freeze pipeline stages at and before MEM
- load_data  out  32  extended load result
- load_valid  out  1  load_data valid, one cycle
- misaligned  out  1  misaligned access detected, one cycle

## Operation
- States: IDLE, BUSY, DONE.
- op = mem_read | mem_write. bad = op & (byte_mask == 0).
- IDLE, op & ~bad:
  - Issue combinationally: dmem_read/dmem_write = mem_read/mem_write, with address, wdata and byte_enable derived from the inputs.
  - Latch address, wdata, mask, funct3, addr[1:0] and direction.
  - mem_stall = 1.
  - Next state: DONE if dmem_resp is already high, else BUSY.
- IDLE, bad:
  - misaligned = 1 for this cycle; no request; mem_stall = 0; stay IDLE.
- BUSY:
  - Re-drive the request from the latched registers. Outputs stay stable regardless of input changes.
  - mem_stall = 1.
  - On dmem_resp: capture dmem_rdata and go to DONE.
- DONE:
  - No request; mem_stall = 0.
  - Loads only: load_valid = 1 and load_data = extracted value from the captured word.
  - Unconditional return to IDLE. The incoming instruction is not examined in DONE, so it is not issued twice.
- Load extraction, shift s = 8*addr[1:0]:
  - LB: sign-extend byte [s+7:s]. LBU: zero-extend the same byte.
  - LH: sign-extend half [s+15:s], s ∈ {0,16}. LHU: zero-extend the same half.
  - LW: whole word.
- dmem_byte_enable = byte_mask for stores, 4'b1111 for loads.
- Unrecognised funct3 with op: treated as bad (mask 0 from upstream).

## Timing
- Reset values (any time rst_n low): state IDLE, all outputs 0, latched registers 0.
- Reset mid-BUSY: request drops immediately; the response is not awaited.
- Minimum access, resp one cycle after issue:
  - Cycle N: issue, stall.
  - Cycle N+1: resp, stall.
  - Cycle N+2: DONE, load_valid, no stall.
- Zero-wait resp in the issue cycle: DONE at N+1.
- dmem_resp outside BUSY or the IDLE issue cycle is ignored.
- load_data is held until the next capture; it is qualified only by load_valid.
- Back-to-back memory ops: the second issues in the cycle after DONE.

## Test plan
- LB from 0x1003, rdata 0x80FF_1234, resp after 3 cycles -> request held stable for 3 cycles with addr 0x1000; stall high 4 cycles; load_data 0xFFFF_FF80, load_valid 1 cycle.
- LHU from 0x2002, rdata 0xBEEF_0000, zero-wait resp -> load_data 0x0000_BEEF in the next cycle; stall high 1 cycle.
- SB rs2 0x0000_00AB to 0x3001, mask 0010 -> dmem_write 1, wdata 0x0000_AB00, byte_enable 0010; no load_valid.
- LW to 0x4002 with mask 0000 -> misaligned pulse 1 cycle; dmem_read never asserted; stall 0.
- rst_n low during BUSY -> dmem_read 0 immediately; state IDLE; a later resp is ignored.
- SW 0x4000 then LW 0x4000 back to back -> second request issues in the cycle after the first DONE; exactly one request per instruction.
